// File: rtl/rca_word_sequencer_if.sv
// rca_word_sequencer_if: operand and result valid/ready channels of the nibble-serial word adder
interface rca_word_sequencer_if #(parameter int WIDTH = 16);
    logic             in_valid, in_ready, cin, sub;
    logic             out_valid, out_ready, cout, ovf;
    logic [WIDTH-1:0] a, b, sum;
    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
endinterface

// File: rtl/rca_word_sequencer.sv
// rca_word_sequencer: WIDTH-bit add/sub built from one 4-bit ripple-carry adder, one nibble per cycle
module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;
    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    assign cout = c[4];
endmodule

module rca_word_sequencer #(parameter int WIDTH = 16) (
    input logic               clk,
    input logic               rst_n,
    rca_word_sequencer_if.slave bus
);
    localparam int NIBS = WIDTH / 4;
    localparam int IW = $clog2(NIBS);
    localparam logic [IW-1:0] LAST = IW'(NIBS - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state;
    logic [IW-1:0]    idx;
    logic             carry, cout_r, ovf_r, nib_cout;
    logic [WIDTH-1:0] a_reg, b_reg, sum_r;
    logic [3:0]       nib_sum;
    logic [3:0]       a_nib [NIBS];
    logic [3:0]       b_nib [NIBS];
    for (genvar n = 0; n < NIBS; n++) begin : g_nib
        assign a_nib[n] = a_reg[4*n +: 4];
        assign b_nib[n] = b_reg[4*n +: 4];
    end
    ripple_carry_adder u_rca (
        .a    (a_nib[idx]),
        .b    (b_nib[idx]),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );
    // Subtraction is folded in at accept time: B is stored inverted and the carry preloaded with 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_reg <= bus.a;
                    b_reg <= bus.sub ? ~bus.b : bus.b;
                    carry <= bus.sub | bus.cin;
                    sum_r <= '0;
                    idx   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    sum_r <= sum_r | (WIDTH'(nib_sum) << {idx, 2'b00});
                    carry <= nib_cout;
                    if (idx == LAST) begin
                        cout_r <= nib_cout;
                        ovf_r  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (nib_sum[3] != a_reg[WIDTH-1]);
                        state  <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_rca_word_sequencer.sv
// tb_rca_word_sequencer: vector table, backpressure, back-to-back and async-reset checks with a result scoreboard
module tb_rca_word_sequencer;
    localparam int WIDTH = 16;
    localparam int NIBS = WIDTH / 4;
    typedef struct { logic [15:0] sum; logic cout; logic ovf; } exp_t;
    typedef struct { logic [15:0] a; logic [15:0] b; logic cin; logic sub;
                     logic [15:0] sum; logic cout; logic ovf; } vec_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0, failures = 0, n_out = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    vec_t tbl [9];
    always #5 clk = ~clk;
    rca_word_sequencer_if #(.WIDTH(WIDTH)) bus ();
    rca_word_sequencer #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Independent reference: signed/unsigned integer arithmetic instead of nibble ripple.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        exp_t e;
        int   sa, sb, sr;
        logic [16:0] r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            r  = {1'b0, a} - {1'b0, b};
            sr = sa - sb;
            e.cout = a >= b;
        end else begin
            r  = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            sr = sa + sb + int'(cin);
            e.cout = r[16];
        end
        e.sum = r[15:0];
        e.ovf = (sr > 32767) || (sr < -32768);
        return e;
    endfunction

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                         input exp_t e, input bit keep);
        bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub; bus.in_valid = 1'b1;
        for (int k = 0; k < 40 && !bus.in_ready; k++) tick;
        chk("accept_ready", bus.in_ready, 1);
        exp_q.push_back(e);
        tick;
        if (!keep) bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick;
        chk("drain", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got sum %h expected no result", bus.sum);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_sum", bus.sum, mon_e.sum);
                chk("sb_cout", bus.cout, mon_e.cout);
                chk("sb_ovf", bus.ovf, mon_e.ovf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        longint t_prev, t_now;
        int     n0;
        logic [15:0] ra, rb;
        logic rc, rs;
        tbl[0] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        tbl[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        tbl[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_sum", bus.sum, 0);
        chk("rst_cout", bus.cout, 0);
        chk("rst_ovf", bus.ovf, 0);
        rst_n = 1'b1;
        tick;
        foreach (tbl[i]) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, exp_t'{tbl[i].sum, tbl[i].cout, tbl[i].ovf}, 1'b0);
            repeat (NIBS - 1) tick;
            chk("latency_early", bus.out_valid, 0);
            tick;
            chk("latency_on", bus.out_valid, 1);
            tick;
            chk("done_release", bus.out_valid, 0);
        end
        // Backpressure with competing operands held on the input channel
        bus.out_ready = 1'b0;
        drive(16'h1234, 16'h1111, 1'b0, 1'b0, exp_t'{16'h2345, 1'b0, 1'b0}, 1'b0);
        for (int k = 0; k < 20 && !bus.out_valid; k++) tick;
        chk("bp_valid", bus.out_valid, 1);
        bus.in_valid = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.cin = 1'b1;
        repeat (5) begin
            tick;
            chk("bp_sum", bus.sum, 16'h2345);
            chk("bp_cout", bus.cout, 0);
            chk("bp_ovf", bus.ovf, 0);
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_out_valid", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick;
        chk("bp_drop", bus.out_valid, 0);
        chk("bp_ready", bus.in_ready, 1);
        chk("bp_consumed", exp_q.size(), 0);
        drive(16'h0F0F, 16'h0101, 1'b0, 1'b0, exp_t'{16'h1010, 1'b0, 1'b0}, 1'b0);
        wait_drain;
        // Back-to-back with in_valid and out_ready held high
        n0 = n_out;
        t_prev = 0;
        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            drive(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b1);
            t_now = $time;
            if (i > 0) chk("b2b_period", 32'(t_now - t_prev), (NIBS + 2) * 10);
            t_prev = t_now;
        end
        bus.in_valid = 1'b0;
        wait_drain;
        chk("b2b_count", n_out - n0, 20);
        // Asynchronous reset two nibbles into an operation
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, exp_t'{16'h0000, 1'b1, 1'b0}, 1'b0);
        wait_drain;
        drive(16'h1111, 16'h1111, 1'b0, 1'b0, model(16'h1111, 16'h1111, 1'b0, 1'b0), 1'b0);
        tick;
        tick;
        chk("pre_rst_cout", bus.cout, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_sum", bus.sum, 0);
        chk("arst_cout", bus.cout, 0);
        exp_q.delete();
        #3 rst_n = 1'b1;
        tick;
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_out_valid", bus.out_valid, 0);
        drive(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, exp_t'{16'h0000, 1'b1, 1'b0}, 1'b0);
        wait_drain;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
